// File: rtl/cpu_run_controller.sv
// cpu_run_controller: run sequencer for pipelined_cpu.
// Holds core reset, runs with a watchdog, counts cycles and retires.
module cpu_run_controller #(
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 50,
  parameter int CNT_W        = 16,
  parameter int RET_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             core_halt,
  input  logic             core_retire,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [RET_W-1:0] retire_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RUN     = 2'd1,
    S_HALTED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST =
    CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [RET_W-1:0] RET_ONE = RET_W'(1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] hold_q;
  logic             hold_end;
  logic             wd_end;

  assign hold_end = (hold_q == HOLD_LAST);
  assign wd_end   = (cycle_count == RUN_LAST);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // next state; restart wins, halt beats watchdog
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = S_HOLD;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (hold_end) state_d = S_RUN;
        end
        S_RUN: begin
          if (core_halt) state_d = S_HALTED;
          else if (wd_end) state_d = S_TIMEOUT;
        end
        S_HALTED:  state_d = S_HALTED;
        S_TIMEOUT: state_d = S_TIMEOUT;
      endcase
    end
  end

  // hold, cycle and retire counters, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q       <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
    end else if (restart) begin
      hold_q       <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
    end else begin
      if (state_q == S_HOLD && hold_q != '1) begin
        hold_q <= hold_q + CNT_ONE;
      end
      if (state_q == S_RUN) begin
        if (cycle_count != '1) begin
          cycle_count <= cycle_count + CNT_ONE;
        end
        if (core_retire && retire_count != '1) begin
          retire_count <= retire_count + RET_ONE;
        end
      end
    end
  end

  assign core_reset = (state_q != S_RUN);
  assign running    = (state_q == S_RUN);
  assign done       = (state_q == S_HALTED);
  assign timeout    = (state_q == S_TIMEOUT);
  assign state      = state_q;

endmodule
